// File: rtl/freq_meter_multi.sv
// Multi-channel frequency meter: counts rising edges of NUM_CH asynchronous
// inputs over back-to-back gate windows and exposes saturated per-channel
// results through a registered channel-select readout.
module freq_meter_multi #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 32,
  parameter  int CLK_HZ = 48000000,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_48MHz,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] freq_in,
  input  logic              en,
  input  logic [1:0]        gate_sel,
  input  logic              freeze,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_ovf,
  output logic              done,
  output logic              valid,
  output logic              missed
);

  // The gate counter only ever holds G-1, which is always below CLK_HZ.
  localparam int GW = $clog2(CLK_HZ);
  localparam logic [GW-1:0] GLEN0 = GW'(CLK_HZ - 1);
  localparam logic [GW-1:0] GLEN1 = GW'(CLK_HZ / 10 - 1);
  localparam logic [GW-1:0] GLEN2 = GW'(CLK_HZ / 100 - 1);
  localparam logic [GW-1:0] GLEN3 = GW'(CLK_HZ / 1000 - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, GATE} state_t;

  state_t            state;
  state_t            state_next;
  logic              load_gate;
  logic              last_cycle;
  logic              counting;
  logic [GW-1:0]     gate_cnt;
  logic [GW-1:0]     gate_reload;

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [NUM_CH-1:0] sync3;
  logic [NUM_CH-1:0] edge_det;

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] pend_ovf;
  logic [CNT_W-1:0]  cand [NUM_CH];
  logic [NUM_CH-1:0] cand_ovf;
  logic [CNT_W-1:0]  result [NUM_CH];
  logic [NUM_CH-1:0] result_ovf;

  // Two-flop synchroniser plus a delay flop per channel for edge detection.
  always_ff @(posedge clk_48MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= freq_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_det = sync2 & ~sync3;

  // Window length for the currently selected gate; only used at a reload.
  always_comb begin
    gate_reload = GLEN0;
    case (gate_sel)
      2'd0:    gate_reload = GLEN0;
      2'd1:    gate_reload = GLEN1;
      2'd2:    gate_reload = GLEN2;
      default: gate_reload = GLEN3;
    endcase
  end

  // State register.
  always_ff @(posedge clk_48MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle control: counting cycle, last window cycle, reload.
  always_comb begin
    state_next = state;
    load_gate  = 1'b0;
    last_cycle = 1'b0;
    counting   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = GATE;
          load_gate  = 1'b1;
        end
      end
      GATE: begin
        if (!en) begin
          state_next = IDLE;
        end else if (gate_cnt == '0) begin
          last_cycle = 1'b1;
          load_gate  = 1'b1;
        end else begin
          counting = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Gate counter: loaded at window start, counts down to the last window cycle.
  always_ff @(posedge clk_48MHz or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
    end else if (load_gate) begin
      gate_cnt <= gate_reload;
    end else if (counting) begin
      gate_cnt <= gate_cnt - 1'b1;
    end
  end

  // Saturating next count per channel; also the value committed at a window end.
  always_comb begin
    cand_ovf = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt[i] == CNT_MAX) begin
        cand[i]     = CNT_MAX;
        cand_ovf[i] = pend_ovf[i] | edge_det[i];
      end else begin
        cand[i]     = cnt[i] + CNT_W'(edge_det[i]);
        cand_ovf[i] = pend_ovf[i];
      end
    end
  end

  // Edge counters advance only on counting cycles and clear otherwise, which
  // covers IDLE, the window boundary and an aborted window alike.
  always_ff @(posedge clk_48MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
      pend_ovf <= '0;
    end else if (counting) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= cand[i];
      end
      pend_ovf <= cand_ovf;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
      pend_ovf <= '0;
    end
  end

  // Commit on the last window cycle unless frozen; a frozen boundary is flagged.
  always_ff @(posedge clk_48MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        result[i] <= '0;
      end
      result_ovf <= '0;
      done       <= 1'b0;
      valid      <= 1'b0;
      missed     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (last_cycle) begin
        if (!freeze) begin
          for (int i = 0; i < NUM_CH; i++) begin
            result[i] <= cand[i];
          end
          result_ovf <= cand_ovf;
          done       <= 1'b1;
          valid      <= 1'b1;
          missed     <= 1'b0;
        end else begin
          missed <= 1'b1;
        end
      end
    end
  end

  // Registered readout; sees the pre-commit result when both happen together.
  always_ff @(posedge clk_48MHz or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_ovf  <= 1'b0;
    end else if (32'(rd_ch) < NUM_CH) begin
      rd_data <= result[rd_ch];
      rd_ovf  <= result_ovf[rd_ch];
    end else begin
      rd_data <= '0;
      rd_ovf  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_meter_multi.sv
// Bench for freq_meter_multi: a 4-channel 32-bit instance and a 3-channel
// 4-bit instance share one stimulus; a window-level model predicts outputs.
module tb_freq_meter_multi;

  localparam int CLK_HZ = 10000;
  localparam int G_TAB [4] = '{10000, 1000, 100, 10};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  freq_in = '0;
  logic        en = 1'b0;
  logic [1:0]  gate_sel = 2'd2;
  logic        freeze = 1'b0;
  logic [1:0]  rd_ch = 2'd0;

  logic [31:0] rd_data_a;
  logic        rd_ovf_a, done_a, valid_a, missed_a;
  logic [3:0]  rd_data_b;
  logic        rd_ovf_b, done_b, valid_b, missed_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  freq_meter_multi #(.NUM_CH(4), .CNT_W(32), .CLK_HZ(CLK_HZ)) dut_main (
    .clk_48MHz(clk), .rst_n(rst_n), .freq_in(freq_in), .en(en),
    .gate_sel(gate_sel), .freeze(freeze), .rd_ch(rd_ch),
    .rd_data(rd_data_a), .rd_ovf(rd_ovf_a), .done(done_a),
    .valid(valid_a), .missed(missed_a)
  );

  freq_meter_multi #(.NUM_CH(3), .CNT_W(4), .CLK_HZ(CLK_HZ)) dut_small (
    .clk_48MHz(clk), .rst_n(rst_n), .freq_in(freq_in[2:0]), .en(en),
    .gate_sel(gate_sel), .freeze(freeze), .rd_ch(rd_ch),
    .rd_data(rd_data_b), .rd_ovf(rd_ovf_b), .done(done_b),
    .valid(valid_b), .missed(missed_b)
  );

  // Waveform generator: square wave of a given period, or a manual level.
  int wave_period [4] = '{0, 0, 0, 0};
  bit manual_level [4] = '{0, 0, 0, 0};
  int phase [4] = '{0, 0, 0, 0};

  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (wave_period[c] > 0) begin
          freq_in[c] = (phase[c] < wave_period[c] / 2);
          phase[c] = (phase[c] + 1) % wave_period[c];
        end else begin
          freq_in[c] = manual_level[c];
          phase[c] = 0;
        end
      end
    end
  end

  // Behavioural model: pin history gives counted edges, counts are unbounded
  // integers per window, saturation is applied only when a result is taken.
  logic [3:0] hist [8];
  int         mc;
  bit         m_gate;
  int         m_rem;
  int         m_cnt [4];
  longint     m_res_a [4];
  bit         m_ovf_a [4];
  longint     m_res_b [3];
  bit         m_ovf_b [3];
  bit         m_done, m_valid, m_missed;
  longint     m_rd_a, m_rd_b;
  bit         m_rdovf_a, m_rdovf_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) hist[i] = '0;
      mc = 8;
      m_gate = 0;
      m_rem = 0;
      for (int c = 0; c < 4; c++) begin
        m_cnt[c] = 0; m_res_a[c] = 0; m_ovf_a[c] = 0;
      end
      for (int c = 0; c < 3; c++) begin
        m_res_b[c] = 0; m_ovf_b[c] = 0;
      end
      m_done = 0; m_valid = 0; m_missed = 0;
      m_rd_a = 0; m_rd_b = 0; m_rdovf_a = 0; m_rdovf_b = 0;
    end else begin
      bit e [4];
      m_rd_a = m_res_a[rd_ch];
      m_rdovf_a = m_ovf_a[rd_ch];
      if (rd_ch < 3) begin
        m_rd_b = m_res_b[rd_ch];
        m_rdovf_b = m_ovf_b[rd_ch];
      end else begin
        m_rd_b = 0;
        m_rdovf_b = 0;
      end
      m_done = 0;
      for (int c = 0; c < 4; c++)
        e[c] = hist[(mc - 2) % 8][c] & ~hist[(mc - 3) % 8][c];
      hist[mc % 8] = freq_in;
      mc++;
      if (!m_gate) begin
        for (int c = 0; c < 4; c++) m_cnt[c] = 0;
        if (en) begin
          m_gate = 1;
          m_rem = G_TAB[gate_sel] - 1;
        end
      end else if (!en) begin
        m_gate = 0;
        for (int c = 0; c < 4; c++) m_cnt[c] = 0;
      end else begin
        for (int c = 0; c < 4; c++) m_cnt[c] += int'(e[c]);
        if (m_rem != 0) begin
          m_rem--;
        end else begin
          if (!freeze) begin
            for (int c = 0; c < 4; c++) begin
              m_res_a[c] = (m_cnt[c] > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : longint'(m_cnt[c]);
              m_ovf_a[c] = (m_cnt[c] > 64'hFFFF_FFFF);
            end
            for (int c = 0; c < 3; c++) begin
              m_res_b[c] = (m_cnt[c] > 15) ? 15 : longint'(m_cnt[c]);
              m_ovf_b[c] = (m_cnt[c] > 15);
            end
            m_done = 1;
            m_valid = 1;
            m_missed = 0;
          end else begin
            m_missed = 1;
          end
          for (int c = 0; c < 4; c++) m_cnt[c] = 0;
          m_rem = G_TAB[gate_sel] - 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit e_v, input logic [1:0] gs_v, input bit fr_v, input logic [1:0] ch_v);
    en = e_v;
    gate_sel = gs_v;
    freeze = fr_v;
    rd_ch = ch_v;
  endtask

  task automatic waitDone(input int limit, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (done_a !== 1'b1 && waited < limit);
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wait_done: done not seen within %0d cycles", limit);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      checkOutput("done_a", 64'(done_a), 64'(m_done));
      checkOutput("valid_a", 64'(valid_a), 64'(m_valid));
      checkOutput("missed_a", 64'(missed_a), 64'(m_missed));
      checkOutput("rd_data_a", 64'(rd_data_a), 64'(m_rd_a));
      checkOutput("rd_ovf_a", 64'(rd_ovf_a), 64'(m_rdovf_a));
      checkOutput("done_b", 64'(done_b), 64'(m_done));
      checkOutput("valid_b", 64'(valid_b), 64'(m_valid));
      checkOutput("missed_b", 64'(missed_b), 64'(m_missed));
      checkOutput("rd_data_b", 64'(rd_data_b), 64'(m_rd_b));
      checkOutput("rd_ovf_b", 64'(rd_ovf_b), 64'(m_rdovf_b));
    end
  end

  // Directed sequence with hand-computed literal expectations.
  initial begin
    int w;
    int dcount;

    applyStimulus(0, 2'd2, 0, 2'd0);
    repeat (3) @(negedge clk);
    checkOutput("reset_rd_data", 64'(rd_data_a), 64'd0);
    checkOutput("reset_valid", 64'(valid_a), 64'd0);
    checkOutput("reset_done", 64'(done_a), 64'd0);
    checkOutput("reset_missed", 64'(missed_a), 64'd0);
    rst_n = 1'b1;

    // 10-clk square wave on ch0 with 100-cycle windows.
    wave_period[0] = 10;
    repeat (20) @(negedge clk);
    applyStimulus(1, 2'd2, 0, 2'd0);
    waitDone(150, w);
    waitDone(150, w);
    checkOutput("t1_done_spacing", 64'(w), 64'd100);
    @(negedge clk);
    checkOutput("t1_ch0", 64'(rd_data_a), 64'd10);
    checkOutput("t1_ch0_ovf", 64'(rd_ovf_a), 64'd0);
    checkOutput("t1_valid", 64'(valid_a), 64'd1);
    checkOutput("t1_small_ch0", 64'(rd_data_b), 64'd10);
    checkOutput("t1_model_ch0", 64'(m_res_a[0]), 64'd10);
    for (int c = 1; c < 4; c++) begin
      applyStimulus(1, 2'd2, 0, 2'(c));
      @(negedge clk);
      checkOutput("t1_idle_ch", 64'(rd_data_a), 64'd0);
    end
    checkOutput("t1_small_out_of_range", 64'(rd_data_b), 64'd0);

    // 4-clk wave on ch1: 25 edges, saturating at 15 in the 4-bit instance.
    wave_period[0] = 0;
    wave_period[1] = 4;
    applyStimulus(1, 2'd2, 0, 2'd1);
    waitDone(150, w);
    waitDone(150, w);
    @(negedge clk);
    checkOutput("t2_main_ch1", 64'(rd_data_a), 64'd25);
    checkOutput("t2_main_ovf", 64'(rd_ovf_a), 64'd0);
    checkOutput("t2_small_sat", 64'(rd_data_b), 64'd15);
    checkOutput("t2_small_ovf", 64'(rd_ovf_b), 64'd1);
    checkOutput("t2_model_sat", 64'(m_res_b[1]), 64'd15);
    wave_period[1] = 0;
    waitDone(150, w);
    waitDone(150, w);
    @(negedge clk);
    checkOutput("t2_stopped", 64'(rd_data_b), 64'd0);
    checkOutput("t2_stopped_ovf", 64'(rd_ovf_b), 64'd0);

    // Freeze across one window boundary.
    wave_period[0] = 10;
    applyStimulus(1, 2'd2, 0, 2'd0);
    waitDone(150, w);
    waitDone(150, w);
    @(negedge clk);
    checkOutput("t3_before", 64'(rd_data_a), 64'd10);
    wave_period[0] = 5;
    applyStimulus(1, 2'd2, 1, 2'd0);
    dcount = 0;
    repeat (110) begin
      @(negedge clk);
      if (done_a === 1'b1) dcount++;
    end
    checkOutput("t3_no_done", 64'(dcount), 64'd0);
    checkOutput("t3_missed", 64'(missed_a), 64'd1);
    checkOutput("t3_held", 64'(rd_data_a), 64'd10);
    applyStimulus(1, 2'd2, 0, 2'd0);
    waitDone(150, w);
    checkOutput("t3_missed_clear", 64'(missed_a), 64'd0);
    checkOutput("t3_read_old_on_commit", 64'(rd_data_a), 64'd10);
    @(negedge clk);
    checkOutput("t3_after", 64'(rd_data_a), 64'd20);

    // gate_sel changes take effect only at the next reload.
    wave_period[0] = 10;
    applyStimulus(1, 2'd3, 0, 2'd0);
    waitDone(150, w);
    checkOutput("t4_window_kept", 64'(w), 64'd99);
    waitDone(20, w);
    checkOutput("t4_short_window", 64'(w), 64'd10);
    @(negedge clk);
    checkOutput("t4_short_count", 64'(rd_data_a), 64'd1);
    applyStimulus(1, 2'd0, 0, 2'd0);
    waitDone(20, w);
    checkOutput("t4_mid_change", 64'(w), 64'd9);
    @(negedge clk);
    checkOutput("t4_short_count2", 64'(rd_data_a), 64'd1);
    applyStimulus(1, 2'd2, 0, 2'd0);
    waitDone(10100, w);
    checkOutput("t4_long_window", 64'(w), 64'd9999);
    @(negedge clk);
    checkOutput("t4_long_count", 64'(rd_data_a), 64'd1000);
    checkOutput("t4_model_long", 64'(m_res_a[0]), 64'd1000);

    // en dropped mid-window, then restarted with a different input rate.
    waitDone(150, w);
    repeat (50) @(negedge clk);
    wave_period[0] = 5;
    applyStimulus(0, 2'd2, 0, 2'd0);
    dcount = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_a === 1'b1) dcount++;
    end
    checkOutput("t5_no_done", 64'(dcount), 64'd0);
    checkOutput("t5_retained", 64'(rd_data_a), 64'd10);
    checkOutput("t5_valid_kept", 64'(valid_a), 64'd1);
    applyStimulus(1, 2'd2, 0, 2'd0);
    waitDone(150, w);
    checkOutput("t5_restart_latency", 64'(w), 64'd101);
    checkOutput("t5_old_on_commit", 64'(rd_data_a), 64'd10);
    @(negedge clk);
    checkOutput("t5_new_count", 64'(rd_data_a), 64'd20);

    // Asynchronous reset mid-window.
    repeat (30) @(negedge clk);
    wave_period[0] = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rd_data", 64'(rd_data_a), 64'd0);
    checkOutput("t6_valid", 64'(valid_a), 64'd0);
    checkOutput("t6_small_rd", 64'(rd_data_b), 64'd0);
    checkOutput("t6_small_valid", 64'(valid_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single edge landing on the last window cycle.
    applyStimulus(1, 2'd2, 0, 2'd2);
    waitDone(150, w);
    repeat (97) @(negedge clk);
    manual_level[2] = 1'b1;
    waitDone(10, w);
    checkOutput("t7_boundary_timing", 64'(w), 64'd3);
    manual_level[2] = 1'b0;
    @(negedge clk);
    checkOutput("t7_closing_window", 64'(rd_data_a), 64'd1);
    checkOutput("t7_small_closing", 64'(rd_data_b), 64'd1);
    checkOutput("t7_model_closing", 64'(m_res_a[2]), 64'd1);
    waitDone(150, w);
    @(negedge clk);
    checkOutput("t7_next_window", 64'(rd_data_a), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter_multi.md
Name: freq_meter_multi

Overview:
- Parametrised successor to the single-channel frequency counter. Measures NUM_CH asynchronous input frequencies at once, on the 48 MHz system clock.
- Gate windows are contiguous and run-time selectable: 1 s, 100 ms, 10 ms or 1 ms. No input edges are lost between windows.
- Counters saturate and flag overflow.
- Per-channel results are readable through a registered channel-select port, which the SPI slave uses. A freeze input holds results coherent during a multi-byte SPI transfer.

Parameters:
- NUM_CH, 4: number of measured input channels (1..16).
- CNT_W, 32: width of the edge counters and results.
- CLK_HZ, 48000000: system clock frequency. Gate length G = CLK_HZ / {1,10,100,1000} for gate_sel = 0/1/2/3, using integer division. CLK_HZ must be >= 2000 so that every G >= 2.
- localparam CH_W = max(1, clog2(NUM_CH)).

Ports:
- clk_48MHz, input, 1: system clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- freq_in, input, NUM_CH: asynchronous signals to measure.
- en, input, 1: measurement enable.
- gate_sel, input, 2: gate length select. Sampled only when a window starts.
- freeze, input, 1: while high, result registers are not updated.
- rd_ch, input, CH_W: channel to read out.
- rd_data, output, CNT_W: result of rd_ch, registered.
- rd_ovf, output, 1: overflow flag of rd_ch, registered.
- done, output, 1: one-cycle pulse when the results are updated.
- valid, output, 1: sticky; at least one result set has been committed since reset.
- missed, output, 1: sticky; a window completed while freeze was high.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State is IDLE.
  - All synchroniser flops, counters, results and ovf flags are 0.
  - rd_data=0, rd_ovf=0, done=0, valid=0, missed=0.
  - Reset takes effect immediately, including in the middle of a window. The partial count is discarded.
- Input conditioning, per channel:
  - Two-flop synchroniser followed by one delay flop.
  - A rising edge is counted on a cycle where s2=1 and s3=0.
  - Latency from pin to counted edge is 3 cycles.
  - Maximum guaranteed input frequency is clk/4.
- FSM, two states:
  - IDLE: counters held at 0, edges ignored. When en=1, go to GATE next cycle and load gate_cnt = G(gate_sel) - 1.
  - GATE, gate_cnt != 0: each channel counter does cnt += edge, then gate_cnt decrements.
  - GATE, gate_cnt == 0 (the last window cycle):
    - Candidate value per channel is cnt + edge, saturated.
    - Counters clear to 0.
    - gate_cnt reloads from the gate_sel value current on this cycle.
    - State stays GATE, so windows are back to back and each is exactly G cycles.
  - GATE with en=0 on any cycle: go to IDLE next cycle, clear counters, no commit. Results, valid and missed are retained.
- Saturation:
  - A counter at all-ones stays all-ones and sets that channel's pending ovf.
  - Pending ovf clears with the counter at the window boundary.
- Commit, on the last window cycle:
  - freeze=0:
    - result[i] and ovf[i] are loaded from the candidates.
    - done=1 on the next cycle, for exactly one cycle.
    - valid=1, and missed=0.
  - freeze=1:
    - Results are unchanged and done stays 0.
    - missed=1.
    - The count is discarded and the next window starts normally.
- Readout:
  - rd_data and rd_ovf are registered from result[rd_ch], with 1-cycle latency after rd_ch changes.
  - If rd_ch >= NUM_CH, rd_data=0 and rd_ovf=0.
  - If a commit and a read happen in the same cycle, the read returns the old value. The new value appears on the following cycle.
- Simultaneous events:
  - An edge on the last window cycle is counted in the closing window.
  - An edge on the first cycle of the next window is counted in the new window.
  - A gate_sel change mid-window has no effect until the next reload.

Test Plan (sim uses CLK_HZ=10000, so G = 10000/1000/100/10):
- Reset, then en=1, gate_sel=2, ch0 square wave with a 10-clk period, other channels idle -> done pulses every 100 cycles, then rd_ch=0 gives rd_data=10 and rd_ovf=0; channels 1..3 read 0; valid=1.
- CNT_W=4, gate_sel=2, ch1 with a 4-clk period -> 25 edges saturate, rd_data=15 and rd_ovf=1. The next window with the input stopped gives 0 and rd_ovf=0.
- freeze=1 across one window boundary -> no done, result unchanged, missed=1. After freeze=0, the next commit gives done=1 and missed=0.
- gate_sel changed from 3 to 0 mid-window -> current window still lasts 10 cycles, the next window lasts 10000 cycles. A 10-clk input gives 1 then 1000.
- en dropped at cycle 50 of a 100-cycle window, then raised again -> no done, old result retained, and the next full window gives the correct count. Separately, rst_n pulsed low mid-window -> all outputs read 0 immediately.
- Edge timed to land exactly on the last window cycle -> it is counted in the closing window, and the new window starts at count 0.
